// File: rtl/gcd_client_pkg.sv
// rtl/gcd_client_pkg.sv - shared types and constants for the GCD stream client
package gcd_client_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] TAPS_DEFAULT  = 32'h80200003;
    // A zero seed would lock the LFSR at zero, so it is replaced by this value
    localparam logic [31:0] SEED_ZERO_SUB = 32'h00000001;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur, input logic [31:0] taps);
        return (cur >> 1) ^ (cur[0] ? taps : 32'h0);
    endfunction

endpackage

// File: rtl/gcd_client_lfsr.sv
// rtl/gcd_client_lfsr.sv - 32-bit Galois LFSR with load and step enable
module gcd_client_lfsr
    import gcd_client_pkg::*;
#(
    parameter logic [31:0] TAPS = TAPS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step,
    output logic [31:0] state
);

    // Load has priority over step; a loaded nonzero value keeps the sequence off zero
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= 32'h0;
        end else if (load) begin
            state <= load_value;
        end else if (step) begin
            state <= lfsr_next(state, TAPS);
        end
    end

endmodule

// File: rtl/gcd_stream_client.sv
// rtl/gcd_stream_client.sv - GCD request generator / response sink; GCD_CLIENT_CYCLES_EN adds a batch cycle counter
module gcd_stream_client
    import gcd_client_pkg::*;
#(
    parameter int          MAX_INFLIGHT = 4,
    parameter logic [31:0] TAPS         = TAPS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic [15:0] cmd_count,
    input  logic [31:0] cmd_seed,
    output logic        req_val,
    input  logic        req_rdy,
    output logic [31:0] req_msg,
    input  logic        resp_val,
    output logic        resp_rdy,
    input  logic [15:0] resp_msg,
    output logic        done_val,
    input  logic        done_rdy,
    output logic [31:0] done_sum,
    output logic [31:0] done_cycles
);

    localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

    state_t      state;
    logic [15:0] count;
    logic [15:0] issued;
    logic [15:0] received;
    logic [3:0]  inflight;
    logic [31:0] sum;
    logic [31:0] lfsr_q;
    logic [31:0] seed_eff;
    logic        cmd_fire;
    logic        req_fire;
    logic        resp_fire;
    logic        done_fire;

    // Handshake flags are decoded from registered state only
    assign cmd_rdy   = (state == IDLE);
    assign resp_rdy  = (state == RUN);
    assign done_val  = (state == DONE);
    assign req_val   = (state == RUN) && (issued < count) && (inflight < MAX_IF);
    assign req_msg   = lfsr_q;
    assign done_sum  = sum;

    assign cmd_fire  = cmd_val && cmd_rdy;
    assign req_fire  = req_val && req_rdy;
    assign resp_fire = resp_val && resp_rdy;
    assign done_fire = done_val && done_rdy;

    assign seed_eff  = (cmd_seed == 32'h0) ? SEED_ZERO_SUB : cmd_seed;

    gcd_client_lfsr #(
        .TAPS(TAPS)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .load      (cmd_fire),
        .load_value(seed_eff),
        .step      (req_fire),
        .state     (lfsr_q)
    );

    // Batch control: accept command, issue/retire requests, hold summary until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 16'h0;
            issued   <= 16'h0;
            received <= 16'h0;
            inflight <= 4'h0;
            sum      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        count    <= cmd_count;
                        issued   <= 16'h0;
                        received <= 16'h0;
                        sum      <= 32'h0;
                        state    <= (cmd_count == 16'h0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (req_fire) begin
                        issued <= issued + 16'd1;
                    end
                    if (resp_fire) begin
                        received <= received + 16'd1;
                        sum      <= sum + {16'h0, resp_msg};
                        if (received + 16'd1 == count) begin
                            state <= DONE;
                        end
                    end
                    case ({req_fire, resp_fire})
                        2'b10:   inflight <= inflight + 4'd1;
                        2'b01:   inflight <= inflight - 4'd1;
                        default: inflight <= inflight;
                    endcase
                end
                DONE: begin
                    if (done_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A response with nothing outstanding is a protocol violation by the GCD unit
    always_ff @(posedge clk) begin
        if (!reset && resp_fire) begin
            assert (inflight != 4'd0);
        end
    end

`ifdef GCD_CLIENT_CYCLES_EN
    logic [31:0] cycles;

    // Counts cycles spent in RUN for the current batch, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= 32'h0;
        end else if (cmd_fire) begin
            cycles <= 32'h0;
        end else if (state == RUN && cycles != 32'hFFFFFFFF) begin
            cycles <= cycles + 32'd1;
        end
    end

    assign done_cycles = cycles;
`else
    assign done_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_gcd_stream_client.sv
// tb/tb_gcd_stream_client.sv - randomized model-checked bench for gcd_stream_client
module tb_gcd_stream_client;

    localparam int          MAXI = 4;
    localparam logic [31:0] TAPS = 32'h80200003;
`ifdef GCD_CLIENT_CYCLES_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cmd_val   = 1'b0;
    logic [15:0] cmd_count = 16'h0;
    logic [31:0] cmd_seed  = 32'h0;
    logic        req_rdy   = 1'b0;
    logic        resp_val  = 1'b0;
    logic [15:0] resp_msg  = 16'h0;
    logic        done_rdy  = 1'b0;
    logic        cmd_rdy;
    logic        req_val;
    logic        resp_rdy;
    logic        done_val;
    logic [31:0] req_msg;
    logic [31:0] done_sum;
    logic [31:0] done_cycles;

    gcd_stream_client #(
        .MAX_INFLIGHT(MAXI),
        .TAPS        (TAPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_val    (cmd_val),
        .cmd_rdy    (cmd_rdy),
        .cmd_count  (cmd_count),
        .cmd_seed   (cmd_seed),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_msg    (req_msg),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_msg   (resp_msg),
        .done_val   (done_val),
        .done_rdy   (done_rdy),
        .done_sum   (done_sum),
        .done_cycles(done_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- observation of DUT transfers ----------------
    logic        s_reset     = 1'b1;
    logic        s_req_fire  = 1'b0;
    logic        s_resp_fire = 1'b0;
    logic [31:0] s_req_msg   = 32'h0;
    logic [31:0] acc_msgs[$];
    int          n_acc = 0;
    int          n_done = 0;
    logic [31:0] last_done_sum = 32'h0;
    logic [31:0] last_done_cycles = 32'h0;

    always @(negedge clk) begin
        s_reset     = reset;
        s_req_fire  = !reset && req_val && req_rdy;
        s_resp_fire = !reset && resp_val && resp_rdy;
        s_req_msg   = req_msg;
        if (s_req_fire) begin
            acc_msgs.push_back(req_msg);
            n_acc++;
        end
        if (!reset && done_val && done_rdy) begin
            last_done_sum    = done_sum;
            last_done_cycles = done_cycles;
            n_done++;
        end
    end

    // ---------------- ready pacing ----------------
    int rdy_mode = 0;

    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0) begin
            req_rdy  = 1'b1;
            done_rdy = 1'b1;
        end else begin
            req_rdy  = ($urandom_range(0, 2) != 0);
            done_rdy = ($urandom_range(0, 2) == 0);
        end
    end

    // ---------------- GCD unit stand-in ----------------
    typedef struct {
        logic [15:0] v;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          rsp_mode    = 0;
    logic [15:0] rsp_fixed   = 16'h1;
    int          dly_min     = 1;
    int          dly_max     = 1;
    int          rsp_release = -1;
    int          rsp_given   = 0;
    int          cyc         = 0;

    function automatic logic [15:0] gcd16(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 16'h0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin : responder
        pend_t p;
        cyc++;
        if (s_reset) begin
            pend.delete();
        end else begin
            if (s_resp_fire && pend.size() > 0) begin
                void'(pend.pop_front());
                rsp_given++;
            end
            if (s_req_fire) begin
                p.v   = (rsp_mode == 1) ? gcd16(s_req_msg[31:16], s_req_msg[15:0]) : rsp_fixed;
                p.due = cyc + int'($urandom_range(dly_min, dly_max)) - 1;
                pend.push_back(p);
            end
        end
        #2;
        if (pend.size() > 0 && pend[0].due <= cyc && (rsp_release < 0 || rsp_given < rsp_release)) begin
            resp_val = 1'b1;
            resp_msg = pend[0].v;
        end else begin
            resp_val = 1'b0;
            resp_msg = 16'($urandom);
        end
    end

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 running batch, 2 summary pending
    int          m_st = 0;
    int          m_count = 0;
    int          m_issued = 0;
    int          m_received = 0;
    int          m_inflight = 0;
    logic [31:0] m_lfsr = 32'h0;
    logic [31:0] m_sum = 32'h0;
    logic [31:0] m_cycles = 32'h0;
    bit          m_valid = 1'b0;
    bit          m_rst = 1'b0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        if (v[0]) return (v >> 1) ^ TAPS;
        return v >> 1;
    endfunction

    function automatic bit m_req_val();
        return (m_st == 1) && (m_issued < m_count) && (m_inflight < MAXI);
    endfunction

    function automatic logic [31:0] exp_cycles();
        return CYC_EN ? m_cycles : 32'h0;
    endfunction

    always @(posedge clk) begin : model_upd
        bit rf, pf;
        if (reset) begin
            m_st = 0; m_issued = 0; m_received = 0; m_inflight = 0;
            m_lfsr = 32'h0; m_sum = 32'h0; m_cycles = 32'h0;
            m_valid = 1'b1; m_rst = 1'b1;
        end else begin
            rf = m_req_val() && req_rdy;
            pf = (m_st == 1) && resp_val;
            case (m_st)
                0: if (cmd_val) begin
                    m_count    = int'(cmd_count);
                    m_lfsr     = (cmd_seed == 32'h0) ? 32'h1 : cmd_seed;
                    m_issued   = 0;
                    m_received = 0;
                    m_sum      = 32'h0;
                    m_cycles   = 32'h0;
                    m_rst      = 1'b0;
                    m_st       = (cmd_count == 16'h0) ? 2 : 1;
                end
                1: begin
                    if (m_cycles != 32'hFFFFFFFF) m_cycles = m_cycles + 32'd1;
                    if (rf) begin
                        m_issued++;
                        m_lfsr = lfsr_step(m_lfsr);
                    end
                    if (pf) begin
                        m_received++;
                        m_sum = m_sum + {16'h0, resp_msg};
                    end
                    m_inflight = m_inflight + int'(rf) - int'(pf);
                    if (pf && m_received == m_count) m_st = 2;
                end
                default: if (done_rdy) m_st = 0;
            endcase
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check1("cmd_rdy", cmd_rdy, m_st == 0);
            check1("req_val", req_val, m_req_val());
            if (m_req_val()) check32("req_msg", req_msg, m_lfsr);
            check1("resp_rdy", resp_rdy, m_st == 1);
            check1("done_val", done_val, m_st == 2);
            if (m_st == 2) begin
                check32("done_sum", done_sum, m_sum);
                check32("done_cycles", done_cycles, exp_cycles());
            end
            if (m_st == 0 && m_rst) begin
                check32("rst_done_sum", done_sum, 32'h0);
                check32("rst_done_cycles", done_cycles, 32'h0);
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_cmd(input int cnt, input logic [31:0] seed);
        bit ok;
        ok = 1'b0;
        cmd_val   = 1'b1;
        cmd_count = 16'(cnt);
        cmd_seed  = seed;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_rdy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check1("cmd_timeout", 1'b0, 1'b1);
        tick();
        cmd_val = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int prev;
        bit ok;
        prev = n_done;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (n_done > prev) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check1("done_timeout", 1'b0, 1'b1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        int cnt;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check1("reset_cmd_rdy", cmd_rdy, 1'b1);
        check1("reset_req_val", req_val, 1'b0);
        check1("reset_resp_rdy", resp_rdy, 1'b0);
        check1("reset_done_val", done_val, 1'b0);
        check32("reset_done_sum", done_sum, 32'h0);
        check32("reset_done_cycles", done_cycles, 32'h0);
        tick();

        // Basic two-request batch, responder returns 1 one cycle after each request
        rsp_mode = 0; rsp_fixed = 16'h1; dly_min = 1; dly_max = 1;
        base = n_acc;
        send_cmd(2, 32'h1);
        @(negedge clk);
        check1("first_req_latency", req_val, 1'b1);
        wait_done(100);
        check32("basic_n_req", 32'(n_acc - base), 32'd2);
        check32("basic_msg0", acc_msgs[base], 32'h00000001);
        check32("basic_msg1", acc_msgs[base + 1], 32'h80200003);
        check32("basic_sum", last_done_sum, 32'h00000002);
        check32("basic_model_sum", m_sum, 32'h00000002);

        // Zero seed is replaced by 1
        base = n_acc;
        send_cmd(3, 32'h0);
        wait_done(100);
        check32("zero_seed_msg0", acc_msgs[base], 32'h00000001);

        // Empty batch goes straight to the summary
        base = n_acc;
        send_cmd(0, 32'h55);
        @(negedge clk);
        check1("zero_count_done_val", done_val, 1'b1);
        check32("zero_count_sum", done_sum, 32'h0);
        wait_done(100);
        check32("zero_count_no_req", 32'(n_acc - base), 32'd0);

        // Inflight cap with responses withheld, then released one at a time
        rsp_fixed = 16'h3;
        rsp_release = rsp_given;
        base = n_acc;
        send_cmd(8, 32'hACE12345);
        repeat (10) tick();
        check32("inflight_cap", 32'(n_acc - base), 32'd4);
        rsp_release = rsp_given + 1;
        repeat (6) tick();
        check32("inflight_release_one", 32'(n_acc - base), 32'd5);
        rsp_release = -1;
        wait_done(200);
        check32("inflight_sum", last_done_sum, 32'd24);

        // Cycle count: one request, response two cycles after it
        rsp_fixed = 16'h9; dly_min = 2; dly_max = 2;
        send_cmd(1, 32'h00000100);
        wait_done(100);
        check32("done_cycles_single", last_done_cycles, CYC_EN ? 32'd3 : 32'd0);

        // Backpressure on request and summary
        rdy_mode = 1; rsp_fixed = 16'h5; dly_min = 1; dly_max = 4;
        base = n_acc;
        send_cmd(100, $urandom);
        wait_done(5000);
        check32("bp_n_req", 32'(n_acc - base), 32'd100);
        check32("bp_sum", last_done_sum, 32'h000001F4);

        // Random batches with real GCD results
        rsp_mode = 1; dly_min = 1; dly_max = 6;
        for (int i = 0; i < 6; i++) begin
            cnt  = int'($urandom_range(1, 30));
            base = n_acc;
            send_cmd(cnt, (i == 2) ? 32'h0 : $urandom);
            wait_done(3000);
            check32("rand_n_req", 32'(n_acc - base), 32'(cnt));
        end

        // Reset in the middle of a batch
        rdy_mode = 0; rsp_mode = 0; rsp_fixed = 16'h1; dly_min = 1; dly_max = 1;
        base = n_acc;
        send_cmd(10, 32'h1);
        for (int k = 0; k < 50 && (n_acc - base) < 3; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check32("midrst_issued", 32'(n_acc - base), 32'd3);
        check1("midrst_cmd_rdy", cmd_rdy, 1'b1);
        check1("midrst_req_val", req_val, 1'b0);
        check1("midrst_done_val", done_val, 1'b0);
        check32("midrst_done_sum", done_sum, 32'h0);
        tick();
        base = n_acc;
        send_cmd(1, 32'h1);
        wait_done(100);
        check32("post_rst_msg0", acc_msgs[base], 32'h00000001);
        check32("post_rst_sum", last_done_sum, 32'h00000001);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_stream_client.md
Name: gcd_stream_client

Overview:
- Initiator end of the GCD val/rdy stream. Accepts a batch command (count, seed) and generates pseudo-random 32-bit operand pairs with an LFSR.
- Issues those pairs as GCD requests and consumes the 16-bit responses, accumulating a checksum.
- Reports a done message when every response has returned. Used as on-chip traffic source/sink for GCD-unit throughput and regression runs.

Parameters:
- MAX_INFLIGHT, 4, max requests issued but not yet responded (1..15).
- TAPS, 32'h80200003, Galois LFSR feedback mask (x^32+x^22+x^2+x+1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_val  in  1  batch command valid
- cmd_rdy  out  1  client can accept command
- cmd_count  in  16  number of GCD requests in batch
- cmd_seed  in  32  initial LFSR state
- req_val  out  1  GCD request valid
- req_rdy  in  1  GCD unit ready
- req_msg  out  32  operand pair {a[31:16], b[15:0]}
- resp_val  in  1  GCD response valid
- resp_rdy  out  1  client ready for response
- resp_msg  in  16  GCD result
- done_val  out  1  batch summary valid
- done_rdy  in  1  summary consumer ready
- done_sum  out  32  sum of all responses, zero-extended, mod 2^32
- done_cycles  out  32  batch cycle count (see Optional Feature)

Behaviour:
- Reset (reset high at clk edge, any state, including mid-batch):
  - state=IDLE; lfsr, issued, received, inflight, sum and cycles all 0.
  - Next cycle: cmd_rdy=1; req_val=0, resp_rdy=0, done_val=0; done_sum=0, done_cycles=0.
  - Outstanding responses are abandoned. resp_rdy=0 in IDLE, so they are never consumed.
- Fire rule: a transfer occurs on any interface only when val && rdy at a rising clk edge.
- States:
  - IDLE: cmd_rdy=1. On cmd fire, latch count and load lfsr (seed==0 loads 32'h1); clear issued, received, sum, cycles. Go to DONE if cmd_count==0, else RUN.
  - RUN: cmd_rdy=0; resp_rdy=1.
    - req_val = (issued < count) && (inflight < MAX_INFLIGHT); req_msg = lfsr.
    - On req fire: issued++; lfsr advances one step.
    - On resp fire: received++; sum += {16'b0, resp_msg}.
    - inflight: +1 on req fire, -1 on resp fire, unchanged if both in the same cycle.
    - When a resp fire makes received == count, go to DONE next cycle.
  - DONE: done_val=1 with done_sum/done_cycles held stable; req_val=0, resp_rdy=0. On done fire, go to IDLE.
- LFSR step (Galois, right shift): next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0). The state never reaches 0.
- req_msg is combinational from the lfsr register; it stays stable while req_val is high and not accepted. req_val never drops without a fire.
- Latency: the first req_val is asserted the cycle after cmd fire. Full throughput is one request per cycle when req_rdy is held high and responses keep inflight < MAX_INFLIGHT.
- Response arriving with inflight==0 cannot occur in RUN (protocol error); behaviour undefined, flagged by assertion in simulation.
- Counters are 16-bit: count=16'hFFFF is legal, and issued/received never wrap.

Optional Feature:
- Macro GCD_CLIENT_CYCLES_EN.
- Defined:
  - 32-bit cycles counter, cleared on cmd fire, increments every cycle in RUN, saturating at 32'hFFFFFFFF.
  - done_cycles = cycles.
- Undefined: no counter logic; done_cycles tied 32'h0.

Decomposition:
- Package gcd_client_pkg: state enum {IDLE, RUN, DONE} (2-bit); TAPS default; SEED_ZERO_SUB = 32'h1.
- Sub-module gcd_client_lfsr: 32-bit register with load (value in) and step enable, TAPS parameter, synchronous reset to 0.
- Control FSM and counters live in the top.

Test Plan:
- Basic two-request batch:
  - Stimulus: cmd count=2, seed=0x00000001, req_rdy=1; model responder returns 0x0001 one cycle after each req.
  - Response: req_msg 0x00000001 then 0x80200003; done_sum=0x00000002.
- Zero-seed substitution: seed=0x00000000 -> first req_msg=0x00000001; count=0 -> done_val the cycle after cmd fire, done_sum=0, no req_val.
- Inflight limit:
  - Stimulus: count=8, MAX_INFLIGHT=4, responder withholds all responses.
  - Response: exactly 4 req fires then req_val=0. Releasing one response allows exactly one more request.
  - Simultaneous req+resp fire leaves inflight unchanged.
- Backpressure:
  - Stimulus: random req_rdy/done_rdy stalls, responder returns 0x0005, count=100.
  - Response: req_msg stable during stalls; done_sum=500 (0x1F4); done_val held until done_rdy.
- Reset mid-batch:
  - Stimulus: assert reset after 3 of count=10 issued.
  - Response: next cycle cmd_rdy=1, req_val=0, done_val=0. A fresh count=1, seed=0x00000001 batch produces req_msg=0x00000001.
- With GCD_CLIENT_CYCLES_EN:
  - Stimulus: count=1, req_rdy=1, response 2 cycles after req fire.
  - Response: done_cycles equals the RUN-state cycle count (3); without the macro done_cycles=0.
